// File: rtl/sonic_circbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module : sonic_circbuf_pkg
// Brief  : Shared ring geometry, pointer type, reader states and wrap helper.
// Rev    : 1.0 - initial release
// ============================================================================
package sonic_circbuf_pkg;

    localparam int DEPTH = 15872;
    localparam int AW    = 14;
    localparam int DW    = 128;

    typedef logic [AW-1:0] ptr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Ring pointers wrap only when they advance past the last slot.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sonic_circbuf_if.sv
`default_nettype none
// ============================================================================
// Module : sonic_circbuf_if
// Brief  : RAM read port plus valid/ready output stream of the ring reader.
// Rev    : 1.0 - initial release
// ============================================================================
interface sonic_circbuf_if #(
    parameter int AW = sonic_circbuf_pkg::AW,
    parameter int DW = sonic_circbuf_pkg::DW
) ();
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/sonic_circbuf_skid.sv
`default_nettype none
// ============================================================================
// Module : sonic_circbuf_skid
// Brief  : Small register FIFO holding returned RAM words until consumed.
// Rev    : 1.0 - initial release
// ============================================================================
module sonic_circbuf_skid #(
    parameter int DW    = 128,
    parameter int SKID  = 4,
    parameter int CNT_W = $clog2(SKID + 1)
) (
    input  wire logic             clk_in,
    input  wire logic             reset_n,
    input  wire logic             clear,
    input  wire logic             push,
    input  wire logic [DW-1:0]    push_data,
    input  wire logic             pop,
    output logic      [DW-1:0]    head_data,
    output logic      [CNT_W-1:0] count
);
    localparam int c_idx_w = (SKID > 1) ? $clog2(SKID) : 1;

    logic [DW-1:0]      r_mem [SKID];
    logic [c_idx_w-1:0] r_wr_idx;
    logic [c_idx_w-1:0] r_rd_idx;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [c_idx_w-1:0] idx_inc(input logic [c_idx_w-1:0] idx);
        return (idx == c_idx_w'(SKID - 1)) ? '0 : idx + c_idx_w'(1);
    endfunction

    always_comb begin
        w_do_pop  = pop && (r_count != '0);
        w_do_push = push && ((r_count != CNT_W'(SKID)) || w_do_pop);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SKID; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_idx] <= push_data;
                r_wr_idx        <= idx_inc(r_wr_idx);
            end
            if (w_do_pop) begin
                r_rd_idx <= idx_inc(r_rd_idx);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign head_data = r_mem[r_rd_idx];
    assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/sonic_circbuf_reader.sv
`default_nettype none
// ============================================================================
// Module : sonic_circbuf_reader
// Brief  : Ring consumer: issues RAM reads behind wr_ptr, streams entries out.
// Rev    : 1.0 - initial release
// ============================================================================
module sonic_circbuf_reader
    import sonic_circbuf_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int SKID   = 4
) (
    input  wire logic        clk_in,
    input  wire logic        reset_n,
    input  wire logic        ena,
    input  wire logic        clear,
    input  wire ptr_t        wr_ptr,
    sonic_circbuf_if.master  bus,
    output ptr_t             rd_ptr,
    output ptr_t             occupancy,
    output logic             busy
);
    localparam int          c_cnt_w      = $clog2(SKID + RD_LAT + 1);
    localparam int          c_skid_cnt_w = $clog2(SKID + 1);
    localparam logic [AW:0] c_depth_ext  = (AW + 1)'(DEPTH);

    state_t                  r_state;
    ptr_t                    r_iptr;
    ptr_t                    r_rd_ptr;
    ptr_t                    r_occ;
    logic [RD_LAT-1:0]       r_vpipe;
    logic [RD_LAT-1:0]       w_vpipe_next;
    logic [AW:0]             w_avail;
    logic [c_cnt_w-1:0]      w_inflight;
    logic [c_cnt_w-1:0]      w_used;
    logic [c_skid_cnt_w-1:0] w_skid_cnt;
    logic                    w_credit;
    logic                    w_issue;
    logic                    w_push;
    logic                    w_pop;

    always_comb begin
        if (wr_ptr >= r_iptr) begin
            w_avail = {1'b0, wr_ptr} - {1'b0, r_iptr};
        end else begin
            w_avail = {1'b0, wr_ptr} + c_depth_ext - {1'b0, r_iptr};
        end
    end

    // Buffered plus in-flight words never exceed SKID, so the skid cannot overflow.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + c_cnt_w'(r_vpipe[i]);
        end
        w_used   = w_inflight + c_cnt_w'(w_skid_cnt);
        w_credit = (w_used < c_cnt_w'(SKID));
        w_issue  = (r_state == RUN) && (w_avail != '0) && w_credit && !clear;
        w_push   = r_vpipe[RD_LAT-1];
        w_pop    = bus.out_valid && bus.out_ready;
    end

    generate
        if (RD_LAT == 1) begin : g_pipe_single
            assign w_vpipe_next = w_issue;
        end else begin : g_pipe_multi
            assign w_vpipe_next = {r_vpipe[RD_LAT-2:0], w_issue};
        end
    endgenerate

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_iptr   <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_vpipe  <= '0;
        end else begin
            r_occ <= w_avail[AW-1:0];
            if (clear) begin
                r_state  <= IDLE;
                r_iptr   <= '0;
                r_rd_ptr <= '0;
                r_vpipe  <= '0;
            end else begin
                r_vpipe <= w_vpipe_next;
                if (w_issue) begin
                    r_iptr <= ptr_inc(r_iptr);
                end
                if (w_push) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                case (r_state)
                    IDLE:    if (ena) r_state <= RUN;
                    RUN:     if (!ena) r_state <= DRAIN;
                    DRAIN: begin
                        // Skid contents are left for the consumer; only the RAM pipe must empty.
                        if (ena) begin
                            r_state <= RUN;
                        end else if (w_inflight == '0) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    sonic_circbuf_skid #(
        .DW    (DW),
        .SKID  (SKID),
        .CNT_W (c_skid_cnt_w)
    ) u_skid (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (w_push),
        .push_data (bus.mem_rd_data),
        .pop       (w_pop),
        .head_data (bus.out_data),
        .count     (w_skid_cnt)
    );

    assign bus.mem_rd_en   = w_issue;
    assign bus.mem_rd_addr = r_iptr;
    assign bus.out_valid   = (w_skid_cnt != '0);
    assign rd_ptr          = r_rd_ptr;
    assign occupancy       = r_occ;
    assign busy            = (r_state != IDLE) || (w_skid_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_sonic_circbuf_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_sonic_circbuf_reader
// Brief  : Directed scenarios plus random traffic against a ring-level model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_sonic_circbuf_reader;
    localparam int DEPTH  = sonic_circbuf_pkg::DEPTH;
    localparam int RD_LAT = 2;
    localparam int SKID   = 4;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic        ena;
    logic        clear;
    logic [13:0] wr_ptr;
    logic [13:0] rd_ptr;
    logic [13:0] occupancy;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] salt;

    sonic_circbuf_if bus ();

    sonic_circbuf_reader dut (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .ena       (ena),
        .clear     (clear),
        .wr_ptr    (wr_ptr),
        .bus       (bus),
        .rd_ptr    (rd_ptr),
        .occupancy (occupancy),
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ram_word(input int a);
        logic [31:0] x;
        x = a;
        return {x * 32'h9E3779B1 ^ salt, ~x, x + salt, x * 32'h85EBCA6B};
    endfunction

    function automatic int winc(input int p);
        return (p == DEPTH - 1) ? 0 : p + 1;
    endfunction

    // Two-cycle RAM: address sampled at one edge, word presented after the next.
    logic        s1_en;
    logic [13:0] s1_addr;
    always @(posedge clk_in) begin
        s1_en   <= bus.mem_rd_en;
        s1_addr <= bus.mem_rd_addr;
        bus.mem_rd_data <= s1_en ? ram_word(int'(s1_addr)) : {$urandom, $urandom, $urandom, $urandom};
    end

    // Ring-level reference: issue/consume pointers, returned-word accounting.
    int   m_iptr, m_optr, m_rptr, m_occ, issued, popped, returned, cyc;
    int   iq[$];
    bit   prev_ena, prev_clear, prev_hold;
    logic [127:0] prev_data;

    always @(negedge clk_in) begin
        if (!reset_n) begin
            m_iptr = 0; m_optr = 0; m_rptr = 0; m_occ = 0;
            issued = 0; popped = 0; returned = 0; cyc = 0;
            iq.delete();
            prev_ena = 0; prev_clear = 0; prev_hold = 0;
        end else begin
            cyc++;
            chk("occupancy", occupancy, m_occ);
            while (iq.size() > 0 && iq[0] + RD_LAT + 1 <= cyc) begin
                void'(iq.pop_front());
                m_rptr = winc(m_rptr);
                returned++;
            end
            chk("rd_ptr", rd_ptr, m_rptr);
            chk("out_valid", bus.out_valid, returned > popped);
            if (prev_hold) chk("hold_data", bus.out_data, prev_data);
            m_occ = (int'(wr_ptr) + DEPTH - m_iptr) % DEPTH;
            if (bus.out_valid && bus.out_ready) begin
                chk("pop_data", bus.out_data, ram_word(m_optr));
                m_optr = winc(m_optr);
                popped++;
            end
            if (bus.mem_rd_en) begin
                chk("issue_addr", bus.mem_rd_addr, m_iptr);
                chk("issue_avail", m_occ != 0, 1'b1);
                chk("issue_allowed", prev_ena && !prev_clear && !clear, 1'b1);
                iq.push_back(cyc);
                m_iptr = winc(m_iptr);
                issued++;
            end
            chk("credit", (issued - popped) <= SKID, 1'b1);
            prev_hold  = bus.out_valid && !bus.out_ready && !clear;
            prev_data  = bus.out_data;
            prev_ena   = ena;
            prev_clear = clear;
            if (clear) begin
                m_iptr = 0; m_optr = 0; m_rptr = 0;
                issued = 0; popped = 0; returned = 0;
                iq.delete();
                prev_hold = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_clear();
        step();
        clear  = 1'b1;
        wr_ptr = '0;
        step();
        clear  = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int first_issue, first_valid, cnt, first_k, last_k, outstanding;
        bit done;
        logic [127:0] d;
        int t3_addr[$];
        int t3_k[$];

        salt          = $urandom;
        reset_n       = 1'b0;
        ena           = 1'b1;
        clear         = 1'b0;
        wr_ptr        = '0;
        bus.out_ready = 1'b0;

        // 1: reset values, then nothing to read with wr_ptr == 0
        repeat (3) step();
        chk("rst_mem_rd_en", bus.mem_rd_en, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_rd_ptr", rd_ptr, 14'd0);
        chk("rst_occupancy", occupancy, 14'd0);
        chk("rst_busy", busy, 1'b0);
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            if (bus.mem_rd_en) cnt++;
        end
        chk("t1_no_issue", cnt, 0);
        chk("t1_out_valid", bus.out_valid, 1'b0);
        chk("t1_rd_ptr", rd_ptr, 14'd0);
        chk("t1_occupancy", occupancy, 14'd0);

        // 2: single entry, latency RD_LAT+1 from issue to out_valid
        step();
        wr_ptr = 14'd1;
        first_issue = -1;
        first_valid = -1;
        d = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            if (bus.mem_rd_en && first_issue < 0) begin
                first_issue = k;
                chk("t2_addr", bus.mem_rd_addr, 14'd0);
            end
            if (bus.out_valid && first_valid < 0) begin
                first_valid = k;
                d = bus.out_data;
            end
        end
        chk("t2_issue_cycle", first_issue, 0);
        chk("t2_valid_cycle", first_valid, RD_LAT + 1);
        chk("t2_data", d, ram_word(0));
        chk("t2_rd_ptr", rd_ptr, 14'd1);

        // 3: stream up to the end of the ring, then wrap
        do_clear();
        ena = 1'b1;
        bus.out_ready = 1'b1;
        wr_ptr = 14'h3DFE;
        done = 1'b0;
        for (int k = 0; k < 20000 && !done; k++) begin
            step();
            if (m_optr == 14'h3DFE && popped == issued) done = 1'b1;
        end
        chk("t3_stream_done", done, 1'b1);
        wr_ptr = 14'd2;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            if (bus.mem_rd_en) begin
                t3_addr.push_back(int'(bus.mem_rd_addr));
                t3_k.push_back(k);
            end
        end
        chk("t3_reads", t3_addr.size(), 4);
        if (t3_addr.size() == 4) begin
            chk("t3_addr0", t3_addr[0], 32'h3DFE);
            chk("t3_addr1", t3_addr[1], 32'h3DFF);
            chk("t3_addr2", t3_addr[2], 32'h0000);
            chk("t3_addr3", t3_addr[3], 32'h0001);
            chk("t3_no_gap", t3_k[3] - t3_k[0], 3);
        end
        chk("t3_rd_ptr", rd_ptr, 14'd2);

        // 4: back-pressure limits reads to SKID, then full-rate delivery
        do_clear();
        bus.out_ready = 1'b0;
        wr_ptr = 14'd10;
        repeat (15) step();
        chk("t4_issued", issued, SKID);
        @(negedge clk_in);
        chk("t4_en_low", bus.mem_rd_en, 1'b0);
        step();
        bus.out_ready = 1'b1;
        cnt = 0; first_k = -1; last_k = -1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk_in);
            if (bus.out_valid && bus.out_ready) begin
                cnt++;
                if (first_k < 0) first_k = k;
                last_k = k;
            end
        end
        chk("t4_delivered", cnt, 10);
        chk("t4_sustained", last_k - first_k, 9);

        // 5: ena dropped with two reads in flight
        do_clear();
        bus.out_ready = 1'b0;
        ena = 1'b0;
        step();
        ena = 1'b1;
        wr_ptr = 14'd2;
        step();
        step();
        ena = 1'b0;
        @(negedge clk_in);
        chk("t5_second_issue", bus.mem_rd_en, 1'b1);
        @(negedge clk_in);
        chk("t5_no_issue", bus.mem_rd_en, 1'b0);
        chk("t5_busy", busy, 1'b1);
        repeat (6) step();
        chk("t5_issued", issued, 2);
        chk("t5_poppable", bus.out_valid, 1'b1);
        bus.out_ready = 1'b1;
        repeat (3) step();
        chk("t5_popped", popped, 2);
        chk("t5_idle", busy, 1'b0);

        // 6: clear with reads in flight and words buffered
        do_clear();
        bus.out_ready = 1'b0;
        ena = 1'b1;
        wr_ptr = 14'd10;
        repeat (5) step();
        clear  = 1'b1;
        wr_ptr = '0;
        step();
        clear  = 1'b0;
        @(negedge clk_in);
        chk("t6_out_valid", bus.out_valid, 1'b0);
        chk("t6_rd_ptr", rd_ptr, 14'd0);
        chk("t6_busy", busy, 1'b0);
        bus.out_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            if (bus.out_valid) cnt++;
        end
        chk("t6_no_stale", cnt, 0);

        // Random traffic: producer advances, ena/ready toggle, occasional clear
        for (int it = 0; it < 3000; it++) begin
            step();
            clear = 1'b0;
            if ($urandom_range(0, 99) < 2) begin
                clear  = 1'b1;
                wr_ptr = '0;
            end else begin
                outstanding = (int'(wr_ptr) + DEPTH - m_optr) % DEPTH;
                if ($urandom_range(0, 1) == 1 && outstanding < 200)
                    wr_ptr = 14'((int'(wr_ptr) + int'($urandom_range(0, 3))) % DEPTH);
            end
            ena           = ($urandom_range(0, 9) != 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
        end
        step();
        clear = 1'b0;
        ena = 1'b1;
        bus.out_ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            step();
            if (m_optr == int'(wr_ptr) && popped == issued) done = 1'b1;
        end
        chk("rand_drain", done, 1'b1);

        // Asynchronous reset in the middle of traffic
        bus.out_ready = 1'b0;
        wr_ptr = 14'((int'(wr_ptr) + 8) % DEPTH);
        repeat (6) step();
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_mem_rd_en", bus.mem_rd_en, 1'b0);
        chk("arst_rd_ptr", rd_ptr, 14'd0);
        chk("arst_occupancy", occupancy, 14'd0);
        chk("arst_busy", busy, 1'b0);
        wr_ptr = '0;
        step();
        reset_n = 1'b1;
        repeat (5) step();
        chk("arst_quiet", bus.out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
